// File: rtl/hazard_ctrl_unit.sv
// Hazard and stall sequencer for the 5-stage MIPS core: load-use bubbles, taken-branch flushes
// and MULT/DIV occupancy. Optional event counters are built in when HAZARD_STATS_EN is defined.
module hazard_ctrl_unit #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_ex,
  input  logic [4:0]  reg_w_addr_ex,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        use_rs_id,
  input  logic        use_rt_id,
  input  logic        md_start_id,
  input  logic        md_is_div_id,
  input  logic        hilo_read_id,
  input  logic        branch_taken_ex,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        md_go,
  output logic        md_busy,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        md_done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic lu;
  logic rs_match, rt_match;
  logic md_hz;
  logic stall;
  logic accept;
  logic last_busy;

  // Load-use: the load in EX writes a register the ID instruction reads; r0 never hazards.
  assign rs_match = use_rs_id && (rs_id == reg_w_addr_ex);
  assign rt_match = use_rt_id && (rt_id == reg_w_addr_ex);
  assign lu       = mem_read_ex && (reg_w_addr_ex != 5'd0) && (rs_match || rt_match);

  assign md_hz     = (state == BUSY) && (hilo_read_id || md_start_id);
  assign stall     = (lu || md_hz) && !branch_taken_ex;
  assign accept    = (state == IDLE) && md_start_id && !lu && !branch_taken_ex;
  assign last_busy = (state == BUSY) && (cnt == CNT_ONE);

  // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = md_is_div_id ? DIV_CNT : MUL_CNT;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are forced low while reset is held, independent of the pipeline inputs.
  always_comb begin
    stall_pc    = rst_n && stall;
    stall_if_id = rst_n && stall;
    flush_if_id = rst_n && branch_taken_ex;
    flush_id_ex = rst_n && (stall || branch_taken_ex);
    md_go       = rst_n && accept;
    md_busy     = rst_n && (state == BUSY);
    md_done     = rst_n && last_busy;
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (branch_taken_ex && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus randomized traffic,
// all compared against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl_unit;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read_ex;
  logic [4:0] reg_w_addr_ex;
  logic [4:0] rs_id, rt_id;
  logic       use_rs_id, use_rt_id;
  logic       md_start_id, md_is_div_id, hilo_read_id, branch_taken_ex;
  logic       stall_pc, stall_if_id, flush_if_id, flush_id_ex;
  logic       md_go, md_busy, md_done;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: remaining busy cycles (0 = idle) and event totals.
  int          rem = 0;
  longint      m_stalls = 0;
  longint      m_flushes = 0;
  logic [6:0]  obs;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_ex(mem_read_ex), .reg_w_addr_ex(reg_w_addr_ex),
    .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .md_start_id(md_start_id), .md_is_div_id(md_is_div_id),
    .hilo_read_id(hilo_read_id), .branch_taken_ex(branch_taken_ex),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .md_go(md_go), .md_busy(md_busy),
`ifdef HAZARD_STATS_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .md_done(md_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    mem_read_ex = 0; reg_w_addr_ex = 0; rs_id = 0; rt_id = 0;
    use_rs_id = 0; use_rt_id = 0; md_start_id = 0; md_is_div_id = 0;
    hilo_read_id = 0; branch_taken_ex = 0;
  endtask

  function automatic logic [6:0] dut_vec();
    return {stall_pc, stall_if_id, flush_if_id, flush_id_ex, md_go, md_busy, md_done};
  endfunction

  // One cycle: compare at negedge against the model, then advance the model past the edge.
  task automatic tick(input string tag);
    bit lu, busy, stall, go;
    logic [6:0] exp_v;
    @(negedge clk);
    lu = mem_read_ex && (reg_w_addr_ex != 0) &&
         ((use_rs_id && rs_id == reg_w_addr_ex) || (use_rt_id && rt_id == reg_w_addr_ex));
    busy  = (rem > 0);
    stall = (lu || (busy && (hilo_read_id || md_start_id))) && !branch_taken_ex;
    go    = !busy && md_start_id && !lu && !branch_taken_ex;
    exp_v = {stall, stall, branch_taken_ex, stall || branch_taken_ex, go, busy, rem == 1};
    obs   = dut_vec();
    check(tag, 32'(obs), 32'(exp_v));
`ifdef HAZARD_STATS_EN
    check({tag, "_scnt"}, stall_cnt, 32'(m_stalls));
    check({tag, "_fcnt"}, flush_cnt, 32'(m_flushes));
`endif
    @(posedge clk);
    #1;
    if (stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if (branch_taken_ex && m_flushes < 64'hFFFF_FFFF) m_flushes++;
    if (busy) rem--;
    else if (go) rem = md_is_div_id ? DIV_LAT : MUL_LAT;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1;
    rem = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic set_lu();
    mem_read_ex = 1; reg_w_addr_ex = 5'd8; rs_id = 5'd8; use_rs_id = 1;
  endtask

  initial begin
    int n_busy, n_done, done_at, n_stall;
    do_reset();

    // Reset state
    tick("reset_idle");
    check("reset_vec", 32'(obs), 32'd0);

    // T1: load-use stall for one cycle, none for r0
    clear_in(); set_lu();
    tick("t1_lu");
    check("t1_stall", 32'(obs[6]), 32'd1);
    clear_in();
    tick("t1_after");
    check("t1_drop", 32'(obs[6]), 32'd0);
    set_lu(); reg_w_addr_ex = 5'd0; rs_id = 5'd0;
    tick("t1_r0");
    check("t1_r0_stall", 32'(obs[6]), 32'd0);

    // T2: MULT occupies exactly MUL_LAT cycles, done on the last
    clear_in(); md_start_id = 1;
    tick("t2_go");
    check("t2_md_go", 32'(obs[2]), 32'd1);
    clear_in();
    n_busy = 0; n_done = 0; done_at = 0;
    for (int i = 0; i < 40; i++) begin
      tick("t2_run");
      if (!obs[1]) break;
      n_busy++;
      if (obs[0]) begin n_done++; done_at = n_busy; end
    end
    check("t2_busy_len", 32'(n_busy), 32'(MUL_LAT));
    check("t2_done_cnt", 32'(n_done), 32'd1);
    check("t2_done_at", 32'(done_at), 32'(MUL_LAT));

    // T3: DIV then MFHI held: stall whole busy window, proceed in first idle cycle
    clear_in(); md_start_id = 1; md_is_div_id = 1;
    tick("t3_go");
    clear_in(); hilo_read_id = 1;
    n_stall = 0; n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      tick("t3_run");
      if (!obs[1]) break;
      n_busy++;
      if (obs[6]) n_stall++;
    end
    check("t3_stall_len", 32'(n_stall), 32'(DIV_LAT));
    check("t3_idle_stall", 32'(obs[6]), 32'd0);

    // Back-to-back: second MULT stalls through busy, accepted in first idle cycle
    clear_in(); md_start_id = 1;
    tick("b2b_go1");
    n_busy = 0;
    for (int i = 0; i < 10; i++) begin
      tick("b2b_wait");
      if (obs[2]) break;
      n_busy++;
    end
    check("b2b_gap", 32'(n_busy), 32'(MUL_LAT));
    clear_in();
    repeat (MUL_LAT) tick("b2b_drain");

    // T4: taken branch beats load-use and mul/div start
    clear_in(); set_lu(); md_start_id = 1; branch_taken_ex = 1;
    tick("t4_br");
    check("t4_flushes", 32'(obs[4:3]), 32'b11);
    check("t4_no_stall_go", 32'({obs[6], obs[2]}), 32'd0);
    clear_in();
    tick("t4_after");
    check("t4_still_idle", 32'(obs[1]), 32'd0);

    // T5: reset mid-DIV at cnt=17, then a fresh MULT
    clear_in(); md_start_id = 1; md_is_div_id = 1;
    tick("t5_go");
    clear_in();
    repeat (DIV_LAT - 17) tick("t5_run");
    check("t5_busy_before", 32'(md_busy), 32'd1);
    #2 set_lu(); branch_taken_ex = 1; rst_n = 0;
    #1 check("t5_async_outs", 32'(dut_vec()), 32'd0);
    @(negedge clk);
    #1 rst_n = 1;
    rem = 0; m_stalls = 0; m_flushes = 0;
    clear_in();
    tick("t5_post_reset");
    md_start_id = 1;
    tick("t5_mult_go");
    clear_in();
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      tick("t5_mult_run");
      if (!obs[1]) break;
      n_busy++;
    end
    check("t5_mult_len", 32'(n_busy), 32'(MUL_LAT));

    // T6: counters after T1 then T4 from a clean reset
    do_reset();
    set_lu(); tick("t6_lu");
    clear_in(); tick("t6_gap");
    set_lu(); md_start_id = 1; branch_taken_ex = 1; tick("t6_br");
    clear_in(); tick("t6_end");
`ifdef HAZARD_STATS_EN
    check("t6_stall_cnt", stall_cnt, 32'd1);
    check("t6_flush_cnt", flush_cnt, 32'd1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      mem_read_ex     = ($urandom_range(0, 1) == 1);
      reg_w_addr_ex   = 5'($urandom_range(0, 3));
      rs_id           = 5'($urandom_range(0, 3));
      rt_id           = 5'($urandom_range(0, 3));
      use_rs_id       = ($urandom_range(0, 3) != 0);
      use_rt_id       = ($urandom_range(0, 1) == 1);
      md_start_id     = ($urandom_range(0, 5) == 0);
      md_is_div_id    = ($urandom_range(0, 3) == 0);
      hilo_read_id    = ($urandom_range(0, 5) == 0);
      branch_taken_ex = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
